// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: fetch entry layout and fetch FSM states.
package fetch_pkg;

  localparam int FETCH_DWIDTH = 32;
  localparam int FETCH_IWIDTH = 32;

  typedef struct packed {
    logic [FETCH_DWIDTH-1:0] pc;
    logic [FETCH_IWIDTH-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear; push and pop may occur in the same cycle,
// including when full, so a streaming consumer never stalls the producer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: issues credit-limited memory requests at the current PC, pairs
// in-order responses with their PCs and hands {instr, pc} to decode; flushes drain stale responses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DWIDTH    = FETCH_DWIDTH,
  parameter int IWIDTH    = FETCH_IWIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [DWIDTH-1:0] Program_Count,
  output logic              Run,
  input  logic              Flush,
  output logic              Imem_Req,
  output logic [DWIDTH-1:0] Imem_Addr,
  input  logic              Imem_Gnt,
  input  logic              Imem_Rvalid,
  input  logic [IWIDTH-1:0] Imem_Rdata,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [IWIDTH-1:0] Instr,
  output logic [DWIDTH-1:0] Instr_PC
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = DWIDTH + IWIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef struct packed {
    logic [DWIDTH-1:0] pc;
    logic [IWIDTH-1:0] instr;
  } entry_t;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_flush_drop;
  logic [CW:0]   w_committed;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_accept;
  logic          w_rvalid_ok;
  logic          w_keep_rsp;
  logic          w_pop;
  logic          w_fifo_clr;

  logic [DWIDTH-1:0] w_aq_head;
  logic [CW-1:0]     w_aq_count;
  logic              w_aq_empty;
  logic              w_aq_full;
  entry_t            w_buf_wdata;
  entry_t            w_buf_head;
  logic [CW-1:0]     w_buf_count;
  logic              w_buf_empty;
  logic              w_buf_full;

  // Credit uses registered counts only, so a pop frees a slot one cycle later.
  assign w_committed = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign w_credit_ok = (w_committed < (CW+1)'(BUF_DEPTH));

  assign w_req       = ~Rst_Core & (r_state == FETCH) & w_credit_ok & ~Flush;
  assign w_accept    = w_req & Imem_Gnt;
  assign w_rvalid_ok = Imem_Rvalid & (r_outstanding != '0);
  assign w_keep_rsp  = ~Rst_Core & w_rvalid_ok & (r_drop_cnt == '0) & ~Flush;
  assign w_pop       = ~Rst_Core & ~w_buf_empty & Instr_Ready & ~Flush;
  assign w_fifo_clr  = Flush;
  assign w_flush_drop = r_outstanding - CW'(w_rvalid_ok);

  assign w_buf_wdata.pc    = w_aq_head;
  assign w_buf_wdata.instr = Imem_Rdata;

  assign Imem_Req    = w_req;
  assign Imem_Addr   = Program_Count;
  assign Run         = ~Rst_Core & (w_accept | Flush);
  assign Instr_Valid = ~Rst_Core & ~w_buf_empty;
  assign Instr       = Rst_Core ? '0 : w_buf_head.instr;
  assign Instr_PC    = Rst_Core ? '0 : w_buf_head.pc;

  fetch_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_addr_q (
    .i_clk   (Clk_Core),
    .i_rst   (Rst_Core),
    .i_clr   (w_fifo_clr),
    .i_push  (w_accept),
    .i_wdata (Program_Count),
    .i_pop   (w_keep_rsp),
    .o_rdata (w_aq_head),
    .o_count (w_aq_count),
    .o_empty (w_aq_empty),
    .o_full  (w_aq_full)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_instr_buf (
    .i_clk   (Clk_Core),
    .i_rst   (Rst_Core),
    .i_clr   (w_fifo_clr),
    .i_push  (w_keep_rsp),
    .i_wdata (w_buf_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_buf_head),
    .o_count (w_buf_count),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop_cnt;
    if (Flush) begin
      // Everything still in flight becomes stale; an Rvalid this cycle is already discarded.
      w_drop_nxt        = w_flush_drop;
      w_outstanding_nxt = w_flush_drop;
      w_state_nxt       = (w_flush_drop != '0) ? DRAIN : FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(w_rvalid_ok);
        end
        DRAIN: begin
          if (w_rvalid_ok) begin
            w_drop_nxt        = r_drop_cnt - CNT_ONE;
            w_outstanding_nxt = r_outstanding - CNT_ONE;
            if (r_drop_cnt == CNT_ONE) w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      r_state       <= FETCH;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_nxt;
    end
  end

  // Protocol and bookkeeping invariants of the credit scheme.
  a_rvalid_without_request: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    !(Imem_Rvalid && (r_outstanding == '0)));
  a_addr_q_overflow: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    !(w_accept && w_aq_full));
  a_addr_q_underflow: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    !(w_keep_rsp && w_aq_empty));
  a_buf_overflow: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    !(w_keep_rsp && w_buf_full && !w_pop));
  a_addr_q_tracks_outstanding: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    (r_state == FETCH) |-> (w_aq_count == r_outstanding));

endmodule
